// File: rtl/gelato_types_pkg.sv
// Shared types and defaults for the gelato memory-side blocks.
package gelato_types;

  localparam int unsigned LINE_WORDS_DEFAULT = 8;
  localparam int unsigned WORD_W             = 32;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    RESP
  } fetch_state_e;

endpackage

// File: rtl/gelato_ram_if.sv
// Word-wide RAM port: master presents a byte address, slave returns data with done.
interface gelato_ram_if #(
  parameter int unsigned ADDR_WIDTH = 32
) ();

  logic [ADDR_WIDTH-1:0] addr;
  logic [31:0]           data;
  logic                  done;

  modport master (output addr, input data, input done);
  modport slave  (input addr, output data, output done);

endinterface

// File: rtl/ram_line_fetcher.sv
// Fetches one aligned line from a word RAM, one word per done, and presents it
// on a valid/ready response port. rdy freezes all state when low.
module ram_line_fetcher
  import gelato_types::*;
#(
  parameter int unsigned LINE_WORDS = LINE_WORDS_DEFAULT,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rdy,
  input  logic                       req_valid,
  input  logic [ADDR_WIDTH-1:0]      req_addr,
  output logic                       req_ready,
  output logic                       resp_valid,
  input  logic                       resp_ready,
  output logic [ADDR_WIDTH-1:0]      resp_addr,
  output logic [LINE_WORDS*32-1:0]   resp_data,
  gelato_ram_if.master               ram
);

  localparam int unsigned IDX_W     = $clog2(LINE_WORDS);
  localparam int unsigned LINE_B    = LINE_WORDS * 4;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LINE_WORDS - 1);
  localparam logic [ADDR_WIDTH-1:0] OFF_MASK = ADDR_WIDTH'(LINE_B - 1);

  fetch_state_e          state_q, state_d;
  logic [IDX_W-1:0]      index_q, index_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic                  word_we;
  logic [WORD_W-1:0]     line_q [LINE_WORDS];

  // Next-state, index and base selection; nothing advances while rdy is low.
  always_comb begin
    state_d = state_q;
    index_d = index_q;
    base_d  = base_q;
    word_we = 1'b0;
    if (rdy) begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            base_d  = req_addr & ~OFF_MASK;
            index_d = '0;
            state_d = FETCH;
          end
        end
        FETCH: begin
          if (ram.done) begin
            word_we = 1'b1;
            index_d = index_q + IDX_W'(1);
            if (index_q == LAST_IDX) begin
              state_d = RESP;
            end
          end
        end
        RESP: begin
          if (resp_ready) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Control state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      index_q <= '0;
      base_q  <= '0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      base_q  <= base_d;
    end
  end

  // Line buffer: one word captured per completed RAM access.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(LINE_WORDS); i++) begin
        line_q[i] <= '0;
      end
    end else if (word_we) begin
      line_q[index_q] <= ram.data;
    end
  end

  // Outputs derived from registered state; address wraps modulo 2^ADDR_WIDTH.
  always_comb begin
    req_ready  = rdy && (state_q == IDLE);
    resp_valid = (state_q == RESP);
    resp_addr  = base_q;
    ram.addr   = (state_q == FETCH) ? base_q + ADDR_WIDTH'({index_q, 2'b00}) : '0;
    for (int i = 0; i < int'(LINE_WORDS); i++) begin
      resp_data[32*i +: 32] = line_q[i];
    end
  end

endmodule

// File: tb/tb_ram_line_fetcher.sv
// Directed bench for ram_line_fetcher with a byte-pattern fake RAM and a response scoreboard.
module tb_ram_line_fetcher;

  localparam int unsigned LW = 8;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = LW * 32;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          rdy;
  logic          req_valid;
  logic [AW-1:0] req_addr;
  logic          req_ready;
  logic          resp_valid;
  logic          resp_ready;
  logic [AW-1:0] resp_addr;
  logic [DW-1:0] resp_data;
  logic          done_drv;

  int   tests = 0;
  int   fails = 0;
  exp_t sb[$];

  gelato_ram_if #(.ADDR_WIDTH(AW)) ram_if ();

  ram_line_fetcher #(.LINE_WORDS(LW), .ADDR_WIDTH(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .rdy        (rdy),
    .req_valid  (req_valid),
    .req_addr   (req_addr),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_addr  (resp_addr),
    .resp_data  (resp_data),
    .ram        (ram_if)
  );

  always #5 clk = ~clk;

  // Fake RAM: byte at address a holds a[7:0].
  function automatic logic [31:0] ram_word(input logic [31:0] a);
    return {8'(a + 32'd3), 8'(a + 32'd2), 8'(a + 32'd1), 8'(a)};
  endfunction

  function automatic logic [DW-1:0] exp_line(input logic [AW-1:0] base);
    logic [DW-1:0] l;
    for (int i = 0; i < int'(LW); i++) begin
      l[32*i +: 32] = ram_word(base + AW'(4 * i));
    end
    return l;
  endfunction

  assign ram_if.data = ram_word(ram_if.addr);
  assign ram_if.done = done_drv;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one request, optionally stall done or drop rdy at a word index, and check latency.
  task automatic run_req(input logic [AW-1:0] a, input int stall_idx, input int stall_n,
                         input int drop_idx, input int drop_n, input int exp_lat);
    logic [AW-1:0] base;
    exp_t e;
    int lat;
    int widx;
    int sn;
    int dn;
    base   = a & ~AW'(LW * 4 - 1);
    e.addr = base;
    e.data = exp_line(base);
    sb.push_back(e);
    sn = stall_n;
    dn = drop_n;
    chk("req_ready_idle", DW'(req_ready), DW'(1));
    req_addr  = a;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    req_addr  = '0;
    lat  = 1;
    widx = 0;
    while (!resp_valid && lat < 100) begin
      chk("fetch_addr", DW'(ram_if.addr), DW'(base + AW'(4 * widx)));
      if (widx == stall_idx && sn > 0) begin
        done_drv = 1'b0;
        repeat (sn) begin
          tick();
          lat++;
          chk("stall_addr_hold", DW'(ram_if.addr), DW'(base + AW'(4 * widx)));
        end
        done_drv = 1'b1;
        sn = 0;
      end
      if (widx == drop_idx && dn > 0) begin
        rdy = 1'b0;
        repeat (dn) begin
          tick();
          lat++;
          chk("frozen_req_ready", DW'(req_ready), DW'(0));
          chk("frozen_addr", DW'(ram_if.addr), DW'(base + AW'(4 * widx)));
        end
        rdy = 1'b1;
        dn = 0;
      end
      tick();
      lat++;
      widx++;
    end
    chk("latency", DW'(lat), DW'(exp_lat));
    chk("resp_valid", DW'(resp_valid), DW'(1));
    chk("resp_ram_addr_zero", DW'(ram_if.addr), DW'(0));
  endtask

  // Hold resp_ready low for hold_n cycles, then take the line and compare against the scoreboard.
  task automatic take_resp(input int hold_n);
    exp_t e;
    if (sb.size() == 0) begin
      chk("sb_nonempty", DW'(0), DW'(1));
      return;
    end
    e = sb.pop_front();
    chk("resp_addr", DW'(resp_addr), DW'(e.addr));
    chk("resp_data", resp_data, e.data);
    resp_ready = 1'b0;
    repeat (hold_n) begin
      tick();
      chk("hold_valid", DW'(resp_valid), DW'(1));
      chk("hold_data", resp_data, e.data);
      chk("hold_addr", DW'(resp_addr), DW'(e.addr));
    end
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    chk("post_take_valid", DW'(resp_valid), DW'(0));
    chk("post_take_req_ready", DW'(req_ready), DW'(1));
  endtask

  initial begin
    rst        = 1'b1;
    rdy        = 1'b1;
    req_valid  = 1'b0;
    req_addr   = '0;
    resp_ready = 1'b0;
    done_drv   = 1'b1;
    repeat (2) tick();
    rst = 1'b0;

    // Reset state.
    chk("rst_resp_valid", DW'(resp_valid), DW'(0));
    chk("rst_resp_addr", DW'(resp_addr), DW'(0));
    chk("rst_resp_data", resp_data, DW'(0));
    chk("rst_ram_addr", DW'(ram_if.addr), DW'(0));
    chk("rst_req_ready", DW'(req_ready), DW'(1));
    rdy = 1'b0;
    #1;
    chk("rdy_low_req_ready", DW'(req_ready), DW'(0));
    rdy = 1'b1;
    #1;

    // Basic line from the first line, unaligned request address.
    run_req(32'h0000_0013, -1, 0, -1, 0, 9);
    chk("word0", DW'(resp_data[31:0]), DW'(32'h0302_0100));
    chk("base_zero", DW'(resp_addr), DW'(0));
    take_resp(5);

    // done stalled for 3 cycles at word 4.
    run_req(32'h0000_0104, 4, 3, -1, 0, 12);
    take_resp(0);

    // Line at the top of the address space.
    run_req(32'hFFFF_FFF0, -1, 0, -1, 0, 9);
    chk("wrap_base", DW'(resp_addr), DW'(32'hFFFF_FFE0));
    take_resp(1);

    // Reset at word 5 (with rdy low) discards the partial line.
    req_addr  = 32'h0000_0240;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    repeat (5) tick();
    chk("pre_rst_addr", DW'(ram_if.addr), DW'(32'h0000_0254));
    rst = 1'b1;
    rdy = 1'b0;
    tick();
    rst = 1'b0;
    chk("midrst_resp_valid", DW'(resp_valid), DW'(0));
    chk("midrst_resp_data", resp_data, DW'(0));
    chk("midrst_resp_addr", DW'(resp_addr), DW'(0));
    chk("midrst_ram_addr", DW'(ram_if.addr), DW'(0));
    rdy = 1'b1;
    #1;
    chk("midrst_req_ready", DW'(req_ready), DW'(1));
    repeat (3) begin
      tick();
      chk("no_stale_resp", DW'(resp_valid), DW'(0));
    end
    run_req(32'h0000_0240, -1, 0, -1, 0, 9);
    take_resp(0);

    // rdy dropped for 4 cycles mid-fetch.
    run_req(32'h0000_0380, 3, 0, 3, 4, 13);
    take_resp(2);

    chk("sb_empty", DW'(sb.size()), DW'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
